ula_sequenciador: RTL and testbench

- Upstream sequencer for the 4-bit combinational ULA.
- Accepts operands and opcode as a stream of words over a valid/ready handshake, then drives A, B and seletor into the ULA.
- Registers the ULA's resultado and computes zero, carry/borrow and error flags, which the ULA does not provide.
- Presents the result downstream over a second valid/ready handshake.

---
 rtl/ula_sequenciador.sv | 121 ++++++++++++
 tb/tb_ula_sequenciador.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// Sequencer feeding operands/opcode into the combinational ULA and returning resultado plus zero/carry/error flags.
// Optional chaining of the previous result as operand A is enabled with ULA_ACUMULADOR_EN.
module ula_sequenciador #(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] dado_in,
  input  logic [2:0]         op_in,
  input  logic               valido_in,
  output logic               pronto_out,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic [2:0]         ula_seletor,
  input  logic [LARGURA-1:0] ula_resultado,
  output logic [LARGURA-1:0] resultado,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_erro,
  output logic               valido_out,
`ifdef ULA_ACUMULADOR_EN
  input  logic               encadeia_in,
`endif
  input  logic               pronto_in
);

  typedef enum logic [1:0] {OCIOSO, CARREGA_B, EXECUTA, RESULTADO} estado_t;

  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SOMA = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  estado_t          estado, proximo;
  logic             transferencia;
  logic             entrega;
  logic             encadeia;
  logic [LARGURA:0] soma;

`ifdef ULA_ACUMULADOR_EN
  assign encadeia = encadeia_in;
`else
  assign encadeia = 1'b0;
`endif

  assign transferencia = valido_in && pronto_out;
  assign entrega       = valido_out && pronto_in;
  assign soma          = {1'b0, ula_a} + {1'b0, ula_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo    = estado;
    pronto_out = 1'b0;
    case (estado)
      OCIOSO: begin
        pronto_out = 1'b1;
        if (transferencia) begin
          if (op_in == OP_NOT || encadeia) proximo = EXECUTA;
          else                             proximo = CARREGA_B;
        end
      end
      CARREGA_B: begin
        pronto_out = 1'b1;
        if (transferencia) proximo = EXECUTA;
      end
      EXECUTA:   proximo = RESULTADO;
      RESULTADO: if (entrega) proximo = OCIOSO;
      default:   proximo = OCIOSO;
    endcase
  end

  // Operand registers; they keep their values after completion until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ula_a       <= '0;
      ula_b       <= '0;
      ula_seletor <= '0;
    end else if (transferencia) begin
      if (estado == OCIOSO) begin
        ula_seletor <= op_in;
        if (encadeia) begin
          ula_a <= resultado;
          ula_b <= (op_in == OP_NOT) ? '0 : dado_in;
        end else begin
          ula_a <= dado_in;
          if (op_in == OP_NOT) ula_b <= '0;
        end
      end else if (estado == CARREGA_B) begin
        ula_b <= dado_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_erro  <= 1'b0;
    end else if (estado == EXECUTA) begin
      resultado <= ula_resultado;
      flag_zero <= (ula_resultado == '0);
      case (ula_seletor)
        OP_SOMA: flag_carry <= soma[LARGURA];
        OP_SUB:  flag_carry <= (ula_a < ula_b);
        default: flag_carry <= 1'b0;
      endcase
      flag_erro <= (ula_seletor[2:1] == 2'b11);
    end
  end

  // Valid rises one cycle into RESULTADO and drops together with the exit to OCIOSO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valido_out <= 1'b0;
    else        valido_out <= (estado == RESULTADO) && !entrega;
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural 4-bit ULA model closing the loop.
module tb_ula_sequenciador;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dado_in;
  logic [2:0] op_in;
  logic       valido_in;
  logic       pronto_out;
  logic [3:0] ula_a, ula_b;
  logic [2:0] ula_seletor;
  logic [3:0] ula_resultado;
  logic [3:0] resultado;
  logic       flag_zero, flag_carry, flag_erro, valido_out;
  logic       pronto_in;
`ifdef ULA_ACUMULADOR_EN
  logic       encadeia_in;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ula_sequenciador #(.LARGURA(4)) dut (
    .clk(clk), .rst_n(rst_n), .dado_in(dado_in), .op_in(op_in),
    .valido_in(valido_in), .pronto_out(pronto_out),
    .ula_a(ula_a), .ula_b(ula_b), .ula_seletor(ula_seletor),
    .ula_resultado(ula_resultado), .resultado(resultado),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_erro(flag_erro),
    .valido_out(valido_out),
`ifdef ULA_ACUMULADOR_EN
    .encadeia_in(encadeia_in),
`endif
    .pronto_in(pronto_in)
  );

  // ULA model: 000 AND, 001 OR, 010 NOT A, 011 NAND, 100 ADD, 101 SUB, 11x -> 0
  always_comb begin
    ula_resultado = 4'h0;
    case (ula_seletor)
      3'b000: ula_resultado = ula_a & ula_b;
      3'b001: ula_resultado = ula_a | ula_b;
      3'b010: ula_resultado = ~ula_a;
      3'b011: ula_resultado = ~(ula_a & ula_b);
      3'b100: ula_resultado = ula_a + ula_b;
      3'b101: ula_resultado = ula_a - ula_b;
      default: ula_resultado = 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [3:0] d, input logic [2:0] op);
    int cnt;
    @(negedge clk);
    dado_in   = d;
    op_in     = op;
    valido_in = 1'b1;
    cnt = 0;
    while (!pronto_out && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) check("word_timeout", 8'd1, 8'd0);
    @(posedge clk);
    #1 valido_in = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [3:0] r,
                            input logic z, input logic c, input logic e);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!valido_out && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_valid"}, {7'd0, valido_out}, 8'd1);
    check({tag, "_res"},   {4'd0, resultado}, {4'd0, r});
    check({tag, "_zero"},  {7'd0, flag_zero}, {7'd0, z});
    check({tag, "_carry"}, {7'd0, flag_carry}, {7'd0, c});
    check({tag, "_erro"},  {7'd0, flag_erro}, {7'd0, e});
    @(negedge clk);
    check({tag, "_done"},  {7'd0, valido_out}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; dado_in = '0; op_in = '0; valido_in = 1'b0; pronto_in = 1'b1;
`ifdef ULA_ACUMULADOR_EN
    encadeia_in = 1'b0;
`endif
    #12;
    check("rst_pronto", {7'd0, pronto_out}, 8'd1);
    check("rst_valid",  {7'd0, valido_out}, 8'd0);
    check("rst_res",    {4'd0, resultado}, 8'd0);
    check("rst_flags",  {5'd0, flag_zero, flag_carry, flag_erro}, 8'd0);
    check("rst_ops",    {ula_a, ula_b}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add 9+8 with explicit latency: valid appears after the second edge following B
    word(4'h9, 3'b100);
    word(4'h8, 3'b000);
    @(negedge clk);
    check("add_lat0", {7'd0, valido_out}, 8'd0);
    @(negedge clk);
    check("add_lat1", {7'd0, valido_out}, 8'd0);
    check("add_lat1_pronto", {7'd0, pronto_out}, 8'd0);
    @(negedge clk);
    check("add_lat2", {7'd0, valido_out}, 8'd1);
    check("add_res", {4'd0, resultado}, 8'h01);
    check("add_flags", {5'd0, flag_zero, flag_carry, flag_erro}, 8'b010);
    @(negedge clk);
    check("add_done", {7'd0, valido_out}, 8'd0);
    check("add_pronto", {7'd0, pronto_out}, 8'd1);

    word(4'hF, 3'b100); word(4'h1, 3'b000);
    get_result("addwrap", 4'h0, 1'b1, 1'b1, 1'b0);

    word(4'h3, 3'b101); word(4'h5, 3'b000);
    get_result("sub_borrow", 4'hE, 1'b0, 1'b1, 1'b0);
    word(4'h7, 3'b101); word(4'h7, 3'b000);
    get_result("sub_zero", 4'h0, 1'b1, 1'b0, 1'b0);

    // Unary NOT skips CARREGA_B
    word(4'hF, 3'b010);
    @(negedge clk);
    check("not_pronto", {7'd0, pronto_out}, 8'd0);
    check("not_b", {4'd0, ula_b}, 8'd0);
    get_result("not", 4'h0, 1'b1, 1'b0, 1'b0);
    word(4'hC, 3'b011); word(4'hA, 3'b111);
    get_result("nand", 4'h7, 1'b0, 1'b0, 1'b0);
    check("nand_sel", {5'd0, ula_seletor}, 8'd3);

    // Downstream backpressure: result holds, input pulses ignored
    pronto_in = 1'b0;
    word(4'h5, 3'b001); word(4'hA, 3'b000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      valido_in = 1'b1; dado_in = 4'h3; op_in = 3'b100;
      check("bp_valid",  {7'd0, valido_out}, 8'd1);
      check("bp_res",    {4'd0, resultado}, 8'h0F);
      check("bp_pronto", {7'd0, pronto_out}, 8'd0);
      @(negedge clk);
      valido_in = 1'b0;
    end
    check("bp_a_held", {ula_a, ula_b}, 8'h5A);
    pronto_in = 1'b1;
    @(negedge clk);
    check("bp_release", {7'd0, valido_out}, 8'd0);

    // Stall in CARREGA_B
    word(4'h3, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pronto", {7'd0, pronto_out}, 8'd1);
      check("stall_valid",  {7'd0, valido_out}, 8'd0);
    end
    word(4'h6, 3'b000);
    get_result("and", 4'h2, 1'b0, 1'b0, 1'b0);

    // Reset aborts an operation waiting for B
    word(4'h9, 3'b100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_pronto", {7'd0, pronto_out}, 8'd1);
    check("abort_res",    {4'd0, resultado}, 8'd0);
    check("abort_ops",    {ula_a, ula_b}, 8'd0);
    check("abort_sel",    {5'd0, ula_seletor}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    word(4'h2, 3'b100); word(4'h3, 3'b000);
    get_result("post_rst", 4'h5, 1'b0, 1'b0, 1'b0);

    // Unsupported opcode still loads B
    word(4'h5, 3'b111); word(4'h2, 3'b000);
    get_result("erro", 4'h0, 1'b1, 1'b0, 1'b1);
    check("erro_b", {4'd0, ula_b}, 8'h02);

`ifdef ULA_ACUMULADOR_EN
    word(4'h6, 3'b100); word(4'h5, 3'b000);
    get_result("acc0", 4'hB, 1'b0, 1'b0, 1'b0);
    encadeia_in = 1'b1;
    word(4'h3, 3'b100);
    encadeia_in = 1'b0;
    get_result("acc1", 4'hE, 1'b0, 1'b0, 1'b0);
    encadeia_in = 1'b1;
    word(4'h4, 3'b100);
    encadeia_in = 1'b0;
    get_result("acc2", 4'h2, 1'b0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
